imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface: receives a byte stream (e.g. from a UART receiver)
//  and writes 32-bit words into the instruction memory write port while holding the CPU. On a good
//  transfer it releases the CPU and pulses a PC restart so execution begins at BASE_ADDR.
//  Frame: SYNC_BYTE, LEN_HI, LEN_LO (word count N), 4*N payload bytes (big-endian words), CSUM (XOR of payload).
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address of word 0; word i written at BASE_ADDR + 4*i
//  MAX_WORDS   256            largest accepted N; N > MAX_WORDS -> error
//  SYNC_BYTE   8'hA5          frame start marker
//  TIMEOUT     1_000_000      max idle cycles between bytes inside a frame before error
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  in_data     in   8   stream byte
//  in_valid    in   1   in_data valid
//  in_ready    out  1   loader can accept; byte taken when in_valid && in_ready
//  im_we       out  1   instruction-memory write enable, one cycle per word
//  im_waddr    out  32  byte address, word-aligned
//  im_wdata    out  32  word; first received byte in [31:24]
//  cpu_hold    out  1   high: CPU must not advance PC or write reg/data memory
//  pc_restart  out  1   one-cycle pulse: PC loads BASE_ADDR
//  done        out  1   sticky: last frame loaded with good checksum
//  error       out  1   sticky: last frame failed (length, checksum, timeout)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; im_we=0, im_waddr=0, im_wdata=0, cpu_hold=0, pc_restart=0,
//   done=0, error=0, word/byte counters=0, csum=0. in_ready=1 (combinational from IDLE).
//  States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, FIN.
//  IDLE: in_ready=1; accepted byte == SYNC_BYTE -> LEN_HI, cpu_hold<=1, done<=0, error<=0, csum<=0;
//   other bytes discarded silently.
//  LEN_HI/LEN_LO: capture N[15:8]/N[7:0]. After LEN_LO: N>MAX_WORDS -> FIN with error; N==0 -> CSUM; else DATA.
//  DATA: shift byte into im_wdata (big-endian), csum ^= byte; 4th byte -> WRITE.
//  WRITE: in_ready=0; im_we=1 exactly this cycle, im_waddr=BASE_ADDR+4*idx; idx++;
//   idx==N -> CSUM, else DATA. Write latency: 1 cycle after 4th byte accepted.
//  CSUM: accepted byte == csum -> FIN good; else FIN with error.
//  FIN (1 cycle, in_ready=0): good -> done<=1, cpu_hold<=0, pc_restart=1 this cycle; error -> error<=1,
//   cpu_hold stays 1 (partial program never runs). Then IDLE.
//  Timeout: in LEN_HI..CSUM, cycle counter resets on each accepted byte; reaching TIMEOUT -> FIN with error.
//   Counter idle in IDLE/WRITE/FIN.
//  New SYNC in IDLE after an error restarts the load (clears error). SYNC value inside a frame is plain data.
//  in_valid with in_ready=0: byte not consumed; source holds it.
//  Async reset mid-frame: immediate return to reset values; cpu_hold drops; memory contents undefined.
//  Counters: idx 16-bit, byte-in-word 2-bit wraps 3->0, timeout counter $clog2(TIMEOUT+1) bits.
// STRUCTURE
//  Shared package: state encoding typedef (loader_state_t), SYNC_BYTE default, frame field widths.
//  Single module; no sub-module. Byte source (UART RX) and a write port on instruction memory live
//  outside; top gates PC/RegWrite/MemWrite enables with cpu_hold and muxes pc_restart into PC.
// TESTING
//  Frame A5 00 02 | 20 08 00 05 | 8C 09 00 00 | CSUM=AC ^ 05 ^ 09... (XOR of 8 payload bytes) -> im_we twice:
//   addr 0 data 2008_0005, addr 4 data 8C09_0000; done=1, pc_restart one pulse, cpu_hold 1->0.
//  Same frame with wrong CSUM -> two writes still occur, error=1, done=0, cpu_hold stays 1, no pc_restart.
//  Garbage 00 FF 13 then valid frame (N=0, CSUM 00) -> garbage ignored, no writes, done=1.
//  A5 01 01 (N=257 > 256) -> error=1 after LEN_LO, no im_we, return to IDLE, next SYNC clears error.
//  in_valid toggled randomly, stall during WRITE; and rst_n low mid-DATA -> correct words/no duplicates;
//   reset forces all outputs to reset values asynchronously. Stop bytes after 2 payload bytes
//   (TIMEOUT=100) -> error at cycle 100 after last byte.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and frame field widths.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_FIN
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         BYTE_W        = 8;
  localparam int         WORD_W        = 32;
  localparam int         LEN_W         = 16;
  localparam int         BIDX_W        = 2;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream loader that writes big-endian words into instruction memory while holding the CPU,
// then releases it with a PC restart pulse once the frame checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int          TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [WORD_W-1:0] im_waddr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              pc_restart,
  output logic              done,
  output logic              error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  loader_state_t     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [BIDX_W-1:0] bcnt_q, bcnt_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [WORD_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              good_q, good_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              take;
  logic              tmo;
  logic [LEN_W-1:0]  n_next;

  assign in_ready   = (state_q != S_WRITE) && (state_q != S_FIN);
  assign take       = in_valid && in_ready;
  assign im_we      = (state_q == S_WRITE);
  assign pc_restart = (state_q == S_FIN) && good_q;
  assign im_waddr   = waddr_q;
  assign im_wdata   = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = err_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    csum_d  = csum_q;
    tcnt_d  = tcnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    good_d  = good_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    tmo     = 1'b0;
    n_next  = '0;

    // Inter-byte watchdog runs only while waiting on the source inside a frame.
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
        if (take) begin
          tcnt_d = '0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          tmo    = 1'b1;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_WRITE: tcnt_d = tcnt_q;
      default: tcnt_d = '0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (take && (in_data == SYNC_BYTE)) begin
          state_d = S_LEN_HI;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          csum_d  = '0;
          idx_d   = '0;
          bcnt_d  = '0;
          good_d  = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (take) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end else if (tmo) begin
          good_d  = 1'b0;
          state_d = S_FIN;
        end
      end
      S_LEN_LO: begin
        n_next = {len_q[15:8], in_data};
        if (take) begin
          len_d = n_next;
          if ({16'd0, n_next} > 32'(MAX_WORDS)) begin
            good_d  = 1'b0;
            state_d = S_FIN;
          end else if (n_next == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end else if (tmo) begin
          good_d  = 1'b0;
          state_d = S_FIN;
        end
      end
      S_DATA: begin
        if (take) begin
          wdata_d = {wdata_q[23:0], in_data};
          csum_d  = csum_q ^ in_data;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            waddr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
            state_d = S_WRITE;
          end
        end else if (tmo) begin
          good_d  = 1'b0;
          state_d = S_FIN;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = ((idx_q + 16'd1) == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (take) begin
          good_d  = (in_data == csum_q);
          state_d = S_FIN;
        end else if (tmo) begin
          good_d  = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        // A failed load keeps the CPU held so a partial program never runs.
        if (good_q) begin
          done_d = 1'b1;
          hold_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      csum_q  <= '0;
      tcnt_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      good_q  <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      csum_q  <= csum_d;
      tcnt_q  <= tcnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      good_q  <= good_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level model predicts writes and final status for each frame.
module tb_imem_loader;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        pc_restart;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int pc_cnt = 0;

  wr_t  exp_q[$];
  logic exp_done, exp_err, exp_hold;
  int   exp_pc = 0;

  imem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (256),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .pc_restart (pc_restart),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Every write the DUT issues must be the next one the model predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (im_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual=%h/%h required=none", im_waddr, im_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (im_waddr !== e.a || im_wdata !== e.d || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL write actual=%h/%h rdy=%b required=%h/%h rdy=0",
                     im_waddr, im_wdata, in_ready, e.a, e.d);
          end
        end
      end
      if (pc_restart) pc_cnt++;
    end
  end

  function automatic logic [7:0] xor_payload(input bytes_t f, input int start, input int n);
    logic [7:0] x = 8'h00;
    for (int k = 0; k < 4 * n; k++) x ^= f[start + k];
    return x;
  endfunction

  // Frame-level model: locate SYNC, read length, emit one write per 4 payload bytes, judge checksum.
  task automatic model_frame(input bytes_t f);
    int i = 0;
    int n;
    while (i < f.size() && f[i] != 8'hA5) i++;
    if (i >= f.size()) return;
    n = int'({f[i + 1], f[i + 2]});
    i += 3;
    if (n > 256) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_hold = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      wr_t e;
      e.a = 32'(4 * w);
      e.d = {f[i + 4 * w], f[i + 4 * w + 1], f[i + 4 * w + 2], f[i + 4 * w + 3]};
      exp_q.push_back(e);
    end
    if (f[i + 4 * n] == xor_payload(f, i, n)) begin
      exp_done = 1'b1; exp_err = 1'b0; exp_hold = 1'b0; exp_pc++;
    end else begin
      exp_done = 1'b0; exp_err = 1'b1; exp_hold = 1'b1;
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was consumed.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n = 0;
    if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_wait actual=0 required=1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  task automatic send_all(input bytes_t f, input bit rnd);
    foreach (f[k]) send_byte(f[k], rnd);
  endtask

  task automatic end_check(input string nm);
    repeat (3) @(negedge clk);
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_done"},  {31'd0, done},     {31'd0, exp_done});
    chk({nm, "_error"}, {31'd0, error},    {31'd0, exp_err});
    chk({nm, "_hold"},  {31'd0, cpu_hold}, {31'd0, exp_hold});
    chk({nm, "_pcpulses"}, 32'(pc_cnt), 32'(exp_pc));
  endtask

  task automatic reset_outputs_check(input string nm);
    chk({nm, "_we"},    {31'd0, im_we},      32'd0);
    chk({nm, "_addr"},  im_waddr,            32'd0);
    chk({nm, "_data"},  im_wdata,            32'd0);
    chk({nm, "_hold"},  {31'd0, cpu_hold},   32'd0);
    chk({nm, "_pc"},    {31'd0, pc_restart}, 32'd0);
    chk({nm, "_done"},  {31'd0, done},       32'd0);
    chk({nm, "_error"}, {31'd0, error},      32'd0);
    chk({nm, "_ready"}, {31'd0, in_ready},   32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t good_f, bad_f, garb_f, long_f, empty_f;
    int cyc;

    good_f  = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h8C, 8'h09, 8'h00, 8'h00, 8'hA8};
    bad_f   = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h8C, 8'h09, 8'h00, 8'h00, 8'hA9};
    garb_f  = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00};
    long_f  = '{8'hA5, 8'h01, 8'h01};
    empty_f = '{8'hA5, 8'h00, 8'h00, 8'h00};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    exp_done = 1'b0; exp_err = 1'b0; exp_hold = 1'b0;
    repeat (2) @(negedge clk);
    reset_outputs_check("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Pin the model against hand-computed values for the reference frame.
    chk("model_csum", {24'd0, xor_payload(good_f, 3, 2)}, 32'h0000_00A8);
    model_frame(good_f);
    chk("model_w0", exp_q[0].d, 32'h2008_0005);
    chk("model_a1", exp_q[1].a, 32'h0000_0004);
    chk("model_w1", exp_q[1].d, 32'h8C09_0000);
    chk("hold_before", {31'd0, cpu_hold}, 32'd0);
    send_byte(good_f[0], 1'b0);
    chk("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    for (int k = 1; k < good_f.size(); k++) send_byte(good_f[k], 1'b0);
    end_check("good");

    model_frame(bad_f);
    send_all(bad_f, 1'b1);
    end_check("badcsum");

    model_frame(garb_f);
    send_all(garb_f, 1'b1);
    end_check("garbage");

    model_frame(long_f);
    send_all(long_f, 1'b0);
    end_check("toolong");
    send_byte(8'hA5, 1'b0);
    chk("sync_clears_error", {31'd0, error}, 32'd0);
    model_frame(empty_f);
    for (int k = 1; k < empty_f.size(); k++) send_byte(empty_f[k], 1'b0);
    end_check("recover");

    // Asynchronous reset in the middle of the payload.
    send_all('{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08}, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_outputs_check("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_done = 1'b0; exp_err = 1'b0; exp_hold = 1'b0;
    end_check("after_reset");
    model_frame(good_f);
    send_all(good_f, 1'b1);
    end_check("reload");

    // Source goes silent after two payload bytes.
    send_all('{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22}, 1'b0);
    cyc = 0;
    while (!error && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc < 99 || cyc > 102) begin
      errors++;
      $display("FAIL timeout_cycles actual=%0d required=99..102", cyc);
    end
    exp_done = 1'b0; exp_err = 1'b1; exp_hold = 1'b1;
    end_check("timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
